// File: rtl/cache_lookup_ctrl.sv
// cache_lookup_ctrl: request-side controller for a 4-way set-associative, write-through,
// no-write-allocate cache. It sits between the CPU and an external tag/data array.
// After reset it clears the valid bits of every set in the array. It then accepts one CPU
// word request at a time and looks up all four ways. Read hits are answered from the array.
// Read misses are refilled from main memory. Writes go through to memory.
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   cpu_req_*            CPU request (valid/ready handshake): we, addr = {tag, index}, wdata
//   cpu_resp_*           one-cycle response pulse with read data and hit flag
//   mem_req_*            main-memory request (valid/ready handshake): we, addr, wdata
//   mem_resp_*           main-memory response pulse with fetched word
//   arr_wrEna/waddress   per-way write enables and write index of the tag/data array
//   arr_raddress         array read index; the arr_isValid/tag/data inputs follow it one cycle later
//   arr_inData           {valid, tag, data} written to every enabled way
module cache_lookup_ctrl #(
    parameter int INDEX_W = 10,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_req_valid,
    output logic                        cpu_req_ready,
    input  logic                        cpu_req_we,
    input  logic [INDEX_W+TAG_W-1:0]    cpu_req_addr,
    input  logic [DATA_W-1:0]           cpu_req_wdata,
    output logic                        cpu_resp_valid,
    output logic [DATA_W-1:0]           cpu_resp_rdata,
    output logic                        cpu_resp_hit,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_req_we,
    output logic [INDEX_W+TAG_W-1:0]    mem_req_addr,
    output logic [DATA_W-1:0]           mem_req_wdata,
    input  logic                        mem_resp_valid,
    input  logic [DATA_W-1:0]           mem_resp_rdata,
    output logic [3:0]                  arr_wrEna,
    output logic [INDEX_W-1:0]          arr_waddress,
    output logic [INDEX_W-1:0]          arr_raddress,
    output logic [TAG_W+DATA_W:0]       arr_inData,
    input  logic [3:0]                  arr_isValid,
    input  logic [4*TAG_W-1:0]          arr_tag,
    input  logic [4*DATA_W-1:0]         arr_data
);
    localparam int AW = INDEX_W + TAG_W;
    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_LOOKUP   = 3'd2;
    localparam logic [2:0] S_UPDATE   = 3'd3;
    localparam logic [2:0] S_MEM_REQ  = 3'd4;
    localparam logic [2:0] S_MEM_WAIT = 3'd5;
    localparam logic [2:0] S_REFILL   = 3'd6;
    localparam logic [2:0] S_RESP     = 3'd7;

    logic [2:0]         state_q, state_d;
    logic [INDEX_W-1:0] init_idx_q, init_idx_d;
    logic [1:0]         rr_q, rr_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               hit_q, hit_d;
    logic [1:0]         way_q, way_d;
    logic [3:0]         vld_q, vld_d;

    logic [3:0]         hit_vec;
    logic [1:0]         hit_way;
    logic [1:0]         victim;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;

    assign req_tag = addr_q[AW-1:INDEX_W];
    assign req_idx = addr_q[INDEX_W-1:0];

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < 4; w++)
            hit_vec[w] = arr_isValid[w] && (arr_tag[w*TAG_W +: TAG_W] == req_tag);
    end

    // lowest matching way wins when several ways hold the same tag
    assign hit_way = hit_vec[0] ? 2'd0 : hit_vec[1] ? 2'd1 : hit_vec[2] ? 2'd2 : 2'd3;
    // vld_q is the valid snapshot taken at lookup; fill an empty way before evicting
    assign victim  = !vld_q[0] ? 2'd0 : !vld_q[1] ? 2'd1 : !vld_q[2] ? 2'd2 :
                     !vld_q[3] ? 2'd3 : rr_q;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        rr_d       = rr_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        hit_d      = hit_q;
        way_d      = way_q;
        vld_d      = vld_q;
        case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                state_d    = &init_idx_q ? S_IDLE : S_INIT;
            end
            S_IDLE: begin
                if (cpu_req_valid) begin
                    we_d    = cpu_req_we;
                    addr_d  = cpu_req_addr;
                    wdata_d = cpu_req_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d   = |hit_vec;
                way_d   = hit_way;
                vld_d   = arr_isValid;
                data_d  = we_q ? '0 : arr_data[hit_way*DATA_W +: DATA_W];
                state_d = |hit_vec ? (we_q ? S_UPDATE : S_RESP) : S_MEM_REQ;
            end
            S_UPDATE:   state_d = S_MEM_REQ;
            S_MEM_REQ:  state_d = mem_req_ready ? S_MEM_WAIT : S_MEM_REQ;
            S_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    data_d  = we_q ? '0 : mem_resp_rdata;
                    state_d = we_q ? S_RESP : S_REFILL;
                end
            end
            S_REFILL: begin
                rr_d    = &vld_q ? rr_q + 2'd1 : rr_q;
                state_d = S_RESP;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            rr_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            way_q      <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            rr_q       <= rr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            hit_q      <= hit_d;
            way_q      <= way_d;
            vld_q      <= vld_d;
        end
    end

    // strobes are forced low while rst is held so nothing fires during reset
    always_comb begin
        cpu_req_ready  = !rst && state_q == S_IDLE;
        cpu_resp_valid = !rst && state_q == S_RESP;
        cpu_resp_rdata = state_q == S_RESP ? data_q : '0;
        cpu_resp_hit   = state_q == S_RESP && hit_q;
        mem_req_valid  = !rst && state_q == S_MEM_REQ;
        mem_req_we     = we_q;
        mem_req_addr   = addr_q;
        mem_req_wdata  = wdata_q;
        arr_wrEna      = rst                  ? 4'b0000 :
                         state_q == S_INIT    ? 4'b1111 :
                         state_q == S_UPDATE  ? 4'b0001 << way_q :
                         state_q == S_REFILL  ? 4'b0001 << victim : 4'b0000;
        arr_waddress   = state_q == S_INIT ? init_idx_q : req_idx;
        arr_raddress   = state_q == S_IDLE ? cpu_req_addr[INDEX_W-1:0] : req_idx;
        arr_inData     = state_q == S_UPDATE ? {1'b1, req_tag, wdata_q} :
                         state_q == S_REFILL ? {1'b1, req_tag, data_q} : '0;
    end
endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// tb_cache_lookup_ctrl: randomized self-checking bench for cache_lookup_ctrl with an array model,
// a main-memory responder and a set-level reference model of the cache.
module tb_cache_lookup_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_we = 1'b0;
    logic [12:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_resp_valid, cpu_resp_hit;
    logic [31:0] cpu_resp_rdata;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
    logic [12:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic [3:0]  arr_wrEna, arr_isValid;
    logic [9:0]  arr_waddress, arr_raddress, rd_idx;
    logic [35:0] arr_inData;
    logic [11:0] arr_tag;
    logic [127:0] arr_data;

    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    cache_lookup_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .arr_wrEna(arr_wrEna), .arr_waddress(arr_waddress), .arr_raddress(arr_raddress),
        .arr_inData(arr_inData), .arr_isValid(arr_isValid), .arr_tag(arr_tag), .arr_data(arr_data)
    );

    // physical tag/data array with a registered read address
    logic [35:0] arr [4][1024];
    always @(posedge clk) begin
        for (int w = 0; w < 4; w++)
            if (arr_wrEna[w]) arr[w][arr_waddress] <= arr_inData;
        rd_idx <= arr_raddress;
    end
    always_comb begin
        arr_isValid = '0;
        arr_tag     = '0;
        arr_data    = '0;
        for (int w = 0; w < 4; w++) begin
            arr_isValid[w]      = arr[w][rd_idx][35];
            arr_tag[3*w +: 3]   = arr[w][rd_idx][34:32];
            arr_data[32*w +: 32] = arr[w][rd_idx][31:0];
        end
    end

    // main memory contents, filled with random words on first touch
    logic [31:0] mem_m [bit [12:0]];
    function automatic logic [31:0] mem_rd(input logic [12:0] a);
        if (!mem_m.exists(a)) mem_m[a] = $urandom;
        return mem_m[a];
    endfunction

    typedef struct { bit we; logic [12:0] addr; logic [31:0] wdata; } mreq_t;
    mreq_t mq[$];
    bit          busy = 0, hold = 0, r_we = 0, watching = 0, addr_moved = 0;
    int          dly = 0, stall_req = 0, stall_seen = 0;
    logic [12:0] r_addr = '0, first_addr = '0;

    // memory responder: decides ready at the falling edge, so an accept lands on the next rising edge
    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (rst) begin
            busy = 0;
            watching = 0;
            mem_req_ready = 1'b0;
        end else begin
            if (busy && !hold) begin
                if (dly == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = r_we ? $urandom : mem_rd(r_addr);
                    busy = 0;
                end else dly--;
            end
            if (mem_req_valid && !busy) begin
                if (!watching) begin
                    watching = 1;
                    first_addr = mem_req_addr;
                end else if (mem_req_addr !== first_addr) addr_moved = 1;
                if (stall_req > 0) begin
                    stall_req--;
                    stall_seen++;
                    mem_req_ready = 1'b0;
                end else mem_req_ready = ($urandom_range(0, 2) != 0);
                if (mem_req_ready) begin
                    mq.push_back(mreq_t'{mem_req_we, mem_req_addr, mem_req_wdata});
                    if (mem_req_we) mem_m[mem_req_addr] = mem_req_wdata;
                    r_we = mem_req_we;
                    r_addr = mem_req_addr;
                    busy = 1;
                    dly = $urandom_range(0, 3);
                    watching = 0;
                end
            end else mem_req_ready = 1'b0;
        end
    end

    // reference model: contents of each set plus the shared replacement pointer
    bit          mv [4][1024];
    logic [2:0]  mt [4][1024];
    logic [31:0] md [4][1024];
    int          rr_m;

    task automatic model_clear();
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 1024; i++) begin
                mv[w][i] = 0;
                mt[w][i] = '0;
                md[w][i] = '0;
            end
        rr_m = 0;
    endtask

    task automatic wait_ready(input int limit, input string tag);
        int t = 0;
        while (cpu_req_ready !== 1'b1 && t < limit) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (cpu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready timeout: ready=%b required 1", tag, cpu_req_ready);
        end
    endtask

    task automatic do_req(input bit we, input logic [12:0] a, input logic [31:0] wd);
        logic [9:0]  idx = a[9:0];
        logic [2:0]  tg = a[12:10];
        int          hw = -1, v = -1, lat = 1;
        bit          exp_hit;
        int          exp_n;
        logic [31:0] exp_rd = '0;
        for (int w = 0; w < 4; w++)
            if (hw < 0 && mv[w][idx] && mt[w][idx] == tg) hw = w;
        exp_hit = hw >= 0;
        exp_n = (we || !exp_hit) ? 1 : 0;
        if (!we && exp_hit) exp_rd = md[hw][idx];
        else if (!we) begin
            exp_rd = mem_rd(a);
            for (int w = 0; w < 4; w++)
                if (v < 0 && !mv[w][idx]) v = w;
            if (v < 0) begin
                v = rr_m;
                rr_m = (rr_m + 1) % 4;
            end
            mv[v][idx] = 1;
            mt[v][idx] = tg;
            md[v][idx] = exp_rd;
        end else if (exp_hit) md[hw][idx] = wd;
        mq.delete();
        wait_ready(2000, "req");
        if (cpu_req_ready !== 1'b1) return;
        cpu_req_valid = 1'b1;
        cpu_req_we = we;
        cpu_req_addr = a;
        cpu_req_wdata = wd;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        while (cpu_resp_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (cpu_resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp timeout addr=%h: resp_valid=%b required 1", a, cpu_resp_valid);
            return;
        end
        vectors++;
        if (cpu_resp_hit !== exp_hit) begin
            errors++;
            $display("FAIL hit addr=%h we=%0d: got %b required %b", a, we, cpu_resp_hit, exp_hit);
        end
        vectors++;
        if (cpu_resp_rdata !== exp_rd) begin
            errors++;
            $display("FAIL rdata addr=%h we=%0d: got %h required %h", a, we, cpu_resp_rdata, exp_rd);
        end
        if (!we && exp_hit) begin
            vectors++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL hit latency addr=%h: got %0d required 2", a, lat);
            end
        end
        @(negedge clk);
        vectors++;
        if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp end addr=%h: valid=%b ready=%b required 0/1", a, cpu_resp_valid, cpu_req_ready);
        end
        vectors++;
        if (mq.size() != exp_n) begin
            errors++;
            $display("FAIL mem req count addr=%h: got %0d required %0d", a, mq.size(), exp_n);
        end else if (exp_n == 1) begin
            vectors++;
            if (mq[0].we !== we || mq[0].addr !== a || (we && mq[0].wdata !== wd)) begin
                errors++;
                $display("FAIL mem req addr=%h: got we=%0d addr=%h wdata=%h required we=%0d addr=%h wdata=%h",
                         a, mq[0].we, mq[0].addr, mq[0].wdata, we, a, wd);
            end
        end
        for (int w = 0; w < 4; w++) begin
            vectors++;
            if (arr[w][idx] !== {mv[w][idx], mt[w][idx], md[w][idx]}) begin
                errors++;
                $display("FAIL array way%0d idx=%h: got %h required %h", w, idx, arr[w][idx],
                         {mv[w][idx], mt[w][idx], md[w][idx]});
            end
        end
    endtask

    task automatic check_entry(input int w, input logic [9:0] idx, input logic [35:0] exp, input string tag);
        vectors++;
        if (arr[w][idx] !== exp) begin
            errors++;
            $display("FAIL %s way%0d idx=%h: got %h required %h", tag, w, idx, arr[w][idx], exp);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (cpu_req_ready !== 0 || cpu_resp_valid !== 0 || mem_req_valid !== 0 || arr_wrEna !== 0 ||
            mem_req_addr !== 0 || cpu_resp_rdata !== 0) begin
            errors++;
            $display("FAIL reset outputs: ready=%b resp=%b memv=%b wrEna=%b required all 0",
                     cpu_req_ready, cpu_resp_valid, mem_req_valid, arr_wrEna);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 1024; i++) begin
            if (arr_wrEna !== 4'hF || arr_waddress !== 10'(i) || cpu_req_ready !== 1'b0 || arr_inData !== 0) bad++;
            @(negedge clk);
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init sweep: %0d bad cycles required 0", bad);
        end
        vectors++;
        if (cpu_req_ready !== 1'b1 || arr_wrEna !== 4'h0) begin
            errors++;
            $display("FAIL init done: ready=%b wrEna=%b required 1/0000", cpu_req_ready, arr_wrEna);
        end
        model_clear();
    endtask

    task automatic test_read_miss();
        mem_m[13'h0A05] = 32'hDEADBEEF;
        do_req(0, 13'h0A05, '0);
        check_entry(0, 10'h205, {1'b1, 3'd2, 32'hDEADBEEF}, "refill");
    endtask

    task automatic test_read_hit();
        do_req(0, 13'h0A05, '0);
    endtask

    task automatic test_victim();
        for (int t = 0; t < 6; t++) do_req(0, {3'(t), 10'h105}, '0);
        check_entry(0, 10'h105, {1'b1, 3'd4, md[0][10'h105]}, "victim0");
        check_entry(1, 10'h105, {1'b1, 3'd5, md[1][10'h105]}, "victim1");
        check_entry(2, 10'h105, {1'b1, 3'd2, md[2][10'h105]}, "keep2");
    endtask

    task automatic test_write();
        do_req(1, 13'h0A05, 32'h12345678);
        check_entry(0, 10'h205, {1'b1, 3'd2, 32'h12345678}, "write hit");
        do_req(0, 13'h0A05, '0);
        do_req(1, 13'h1205, 32'hCAFEF00D);
        check_entry(1, 10'h205, 36'h0, "write miss");
    endtask

    task automatic test_stall();
        addr_moved = 0;
        stall_seen = 0;
        stall_req = 5;
        do_req(0, 13'h1777, '0);
        vectors++;
        if (stall_seen != 5 || addr_moved) begin
            errors++;
            $display("FAIL stall: stalled %0d moved=%0d required 5/0", stall_seen, addr_moved);
        end
    endtask

    task automatic test_random();
        logic [9:0] idx;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: idx = 10'h205;
                1: idx = 10'h105;
                2: idx = 10'h3FF;
                default: idx = 10'h000;
            endcase
            do_req($urandom_range(0, 3) == 0, {3'($urandom_range(0, 7)), idx}, $urandom);
        end
    endtask

    task automatic test_reset_midop();
        int t = 0;
        hold = 1;
        wait_ready(2000, "midop");
        cpu_req_valid = 1'b1;
        cpu_req_we = 1'b0;
        cpu_req_addr = 13'h12AA;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        while (!busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (!busy) begin
            errors++;
            $display("FAIL midop mem accept: busy=%0d required 1", busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_req_valid !== 0 || cpu_req_ready !== 0 || cpu_resp_valid !== 0) begin
            errors++;
            $display("FAIL midop reset: memv=%b ready=%b resp=%b required 0", mem_req_valid, cpu_req_ready, cpu_resp_valid);
        end
        rst = 1'b0;
        hold = 0;
        #1;
        vectors++;
        if (arr_wrEna !== 4'hF || arr_waddress !== 10'h0) begin
            errors++;
            $display("FAIL init restart: wrEna=%b waddr=%h required 1111/000", arr_wrEna, arr_waddress);
        end
        model_clear();
        wait_ready(1100, "reinit");
        do_req(0, 13'h0A05, '0);
        do_req(0, 13'h0A05, '0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_victim();
        test_write();
        test_stall();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
